core_stream_bridge: RTL and testbench

- Parametrised next-generation front end for the MNIST accelerator core.
- Accepts multi-lane pixel beats under a valid/ready handshake and serialises them to the core's one-pixel-per-cycle input. Tracks frame boundaries and flow-controls whole frames against result-buffer space.
- Returns each classified digit with a frame tag through a buffered valid/ready result port.

---
 rtl/core_stream_bridge.sv | 231 +++++++++++++++++++++++
 tb/tb_core_stream_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_stream_bridge.sv
// Generic single-clock FIFO: registered storage, head entry shown combinationally.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: pop_vld drops when empty; a push while full is dropped.
module gen_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign pop_vld = (cnt_q != '0);
    assign pop_dat = mem_q[rd_ptr_q];

    // Pointer and occupancy update; simultaneous push and pop both take effect.
    always_comb begin
        do_push  = push_vld & (cnt_q != FULL_CNT);
        do_pop   = pop_vld & pop_rdy;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

// MNIST core front end: serialises LANES-pixel beats to 1 pixel/cycle and tags results.
// Latency: beat accepted at t drives lane k at t+1+k; result visible the cycle after core_o_valid.
// Backpressure: s_ready only on the last lane, and a new frame waits until results have room.
module core_stream_bridge #(
    parameter int DATA_WIDTH   = 8,
    parameter int LANES        = 4,
    parameter int FRAME_PIXELS = 784,
    parameter int RES_DEPTH    = 4,
    parameter int TAG_WIDTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [LANES*DATA_WIDTH-1:0] s_pixels,
    input  logic                        s_last,
    output logic                        core_i_valid,
    output logic [DATA_WIDTH-1:0]       core_pixel,
    input  logic                        core_o_valid,
    input  logic [3:0]                  core_digit,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [3:0]                  m_digit,
    output logic [TAG_WIDTH-1:0]        m_tag,
    output logic                        frame_err
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PIX_W  = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam int CNT_W  = $clog2(RES_DEPTH + 1);
    localparam int RES_W  = TAG_WIDTH + 4;
    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0]    LANE_ONE  = LANE_W'(1);
    localparam logic [PIX_W-1:0]     LAST_BEAT = PIX_W'(FRAME_PIXELS - LANES);
    localparam logic [PIX_W-1:0]     PIX_STEP  = PIX_W'(LANES);
    localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(RES_DEPTH);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [TAG_WIDTH-1:0] TAG_ONE   = TAG_WIDTH'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                               state_q, state_d;
    logic [LANES-1:0][DATA_WIDTH-1:0]     buf_q, buf_d;
    logic [LANE_W-1:0]                    lane_q, lane_d;
    logic                                 last_q, last_d;
    logic [PIX_W-1:0]                     pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]                     in_flight_q, in_flight_d;
    logic [CNT_W-1:0]                     outstanding_q, outstanding_d;
    logic [TAG_WIDTH-1:0]                 tag_cnt_q, tag_cnt_d;
    logic                                 frame_err_q, frame_err_d;

    logic             admit, beat_acc, frame_start, beat_is_last, frame_sent;
    logic             res_push, res_pop, fifo_vld;
    logic [RES_W-1:0] fifo_dat;

    // Handshake and frame-level events; admission looks at registered in_flight only.
    always_comb begin
        admit        = (pix_cnt_q != '0) | (in_flight_q < DEPTH_CNT);
        s_ready      = ~rst & ((state_q == IDLE) | (lane_q == LAST_LANE)) & admit;
        beat_acc     = s_valid & s_ready;
        beat_is_last = (pix_cnt_q == LAST_BEAT);
        frame_start  = beat_acc & (pix_cnt_q == '0);
        frame_sent   = (state_q == SHIFT) & (lane_q == LAST_LANE) & last_q;
        res_pop      = fifo_vld & m_ready;
        res_push     = core_o_valid & (outstanding_q != '0);
    end

    // Serialiser FSM: load a beat, walk its lanes, reload on the last lane without a bubble.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        lane_d  = lane_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (beat_acc) begin
                    state_d = SHIFT;
                    buf_d   = s_pixels;
                    lane_d  = '0;
                    last_d  = beat_is_last;
                end
            end
            SHIFT: begin
                if (lane_q == LAST_LANE) begin
                    if (beat_acc) begin
                        buf_d  = s_pixels;
                        lane_d = '0;
                        last_d = beat_is_last;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lane_d = lane_q + LANE_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame counters, result bookkeeping and the sticky protocol error.
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (beat_acc) pix_cnt_d = beat_is_last ? '0 : pix_cnt_q + PIX_STEP;

        case ({frame_start, res_pop})
            2'b10:   in_flight_d = in_flight_q + CNT_ONE;
            2'b01:   in_flight_d = in_flight_q - CNT_ONE;
            default: in_flight_d = in_flight_q;
        endcase

        case ({frame_sent, res_push})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase

        tag_cnt_d = res_push ? tag_cnt_q + TAG_ONE : tag_cnt_q;

        frame_err_d = frame_err_q
                    | (beat_acc & (s_last != beat_is_last))
                    | (core_o_valid & (outstanding_q == '0));
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            buf_q         <= '0;
            lane_q        <= '0;
            last_q        <= 1'b0;
            pix_cnt_q     <= '0;
            in_flight_q   <= '0;
            outstanding_q <= '0;
            tag_cnt_q     <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            lane_q        <= lane_d;
            last_q        <= last_d;
            pix_cnt_q     <= pix_cnt_d;
            in_flight_q   <= in_flight_d;
            outstanding_q <= outstanding_d;
            tag_cnt_q     <= tag_cnt_d;
            frame_err_q   <= frame_err_d;
        end
    end

    gen_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (res_push),
        .push_dat ({tag_cnt_q, core_digit}),
        .pop_vld  (fifo_vld),
        .pop_rdy  (m_ready),
        .pop_dat  (fifo_dat)
    );

    assign core_i_valid       = (state_q == SHIFT);
    assign core_pixel         = core_i_valid ? buf_q[lane_q] : '0;
    assign m_valid            = fifo_vld;
    assign {m_tag, m_digit}   = fifo_vld ? fifo_dat : '0;
    assign frame_err          = frame_err_q;
endmodule

// File: tb/tb_core_stream_bridge.sv
// Bench for core_stream_bridge: pixel and result scoreboards fed at stimulus time.
// Inputs change 1ns after posedge; DUT outputs are sampled on negedge.
// Covers streaming, frame admission stall, s_last errors, spurious results, reset, result hold.
module tb_core_stream_bridge;
    localparam int DW    = 8;
    localparam int LANES = 4;
    localparam int FP    = 784;
    localparam int DEPTH = 4;
    localparam int TW    = 8;
    localparam int BEATS = FP / LANES;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [LANES*DW-1:0]   s_pixels = '0;
    logic                  s_last = 1'b0;
    logic                  core_i_valid;
    logic [DW-1:0]         core_pixel;
    logic                  core_o_valid = 1'b0;
    logic [3:0]            core_digit = '0;
    logic                  m_valid;
    logic                  m_ready = 1'b1;
    logic [3:0]            m_digit;
    logic [TW-1:0]         m_tag;
    logic                  frame_err;

    core_stream_bridge #(
        .DATA_WIDTH   (DW),
        .LANES        (LANES),
        .FRAME_PIXELS (FP),
        .RES_DEPTH    (DEPTH),
        .TAG_WIDTH    (TW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_pixels     (s_pixels),
        .s_last       (s_last),
        .core_i_valid (core_i_valid),
        .core_pixel   (core_pixel),
        .core_o_valid (core_o_valid),
        .core_digit   (core_digit),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_digit      (m_digit),
        .m_tag        (m_tag),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0]   pix_q[$];
    logic [TW+3:0]   res_q[$];
    int              outst = 0;
    logic [TW-1:0]   tag_m = '0;
    int              run_cnt = 0;
    int              last_run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pixel scoreboard and core_i_valid run-length tracking.
    always @(negedge clk) begin
        if (rst) begin
            run_cnt = 0;
        end else begin
            if (core_i_valid) begin
                run_cnt++;
                if (pix_q.size() == 0) chk("pix_extra", {31'd0, core_i_valid}, 32'd0);
                else chk("pix", {24'd0, core_pixel}, {24'd0, pix_q.pop_front()});
            end else if (run_cnt != 0) begin
                last_run = run_cnt;
                run_cnt  = 0;
            end
        end
    end

    // Result scoreboard: compared whenever the DUT hands off a result.
    always @(negedge clk) begin
        logic [TW+3:0] e;
        if (!rst && m_valid && m_ready) begin
            if (res_q.size() == 0) begin
                chk("res_extra", {31'd0, m_valid}, 32'd0);
            end else begin
                e = res_q.pop_front();
                chk("res_tag", {24'd0, m_tag}, {24'd0, e[TW+3:4]});
                chk("res_digit", {28'd0, m_digit}, {28'd0, e[3:0]});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        core_o_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pix_q.delete();
        res_q.delete();
        outst = 0;
        tag_m = '0;
    endtask

    // Send nbeats beats from the start of a frame; mode 0 = index pattern, 1 = random.
    task automatic send_beats(input int nbeats, input int mode, input bit bad_last);
        logic [LANES*DW-1:0] pix;
        int n;
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < LANES; l++)
                pix[l*DW +: DW] = (mode == 0) ? DW'(b * LANES + l) : DW'($urandom);
            s_pixels = pix;
            s_last   = (b == BEATS - 1);
            if (bad_last && b == 100) s_last = 1'b1;
            if (bad_last && b == BEATS - 1) s_last = 1'b0;
            s_valid  = 1'b1;
            n = 0;
            @(negedge clk);
            while (!s_ready && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (!s_ready) begin
                chk("ready_timeout", {31'd0, s_ready}, 32'd1);
                s_valid = 1'b0;
                return;
            end
            for (int l = 0; l < LANES; l++) pix_q.push_back(pix[l*DW +: DW]);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain_pixels();
        int n = 0;
        @(negedge clk);
        while ((pix_q.size() != 0 || core_i_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("pix_drain", pix_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int mode, input bit bad_last);
        send_beats(BEATS, mode, bad_last);
        drain_pixels();
        outst++;
    endtask

    task automatic pulse_digit(input logic [3:0] d);
        core_digit   = d;
        core_o_valid = 1'b1;
        @(posedge clk);
        #1;
        core_o_valid = 1'b0;
        if (outst > 0) begin
            res_q.push_back({tag_m, d});
            tag_m++;
            outst--;
        end
    endtask

    task automatic drain_results();
        int n = 0;
        while (res_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("res_drain", res_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [TW+3:0] head;

        // Reset state
        @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_core_i_valid", {31'd0, core_i_valid}, 32'd0);
        chk("rst_core_pixel", {24'd0, core_pixel}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_digit", {28'd0, m_digit}, 32'd0);
        chk("rst_m_tag", {24'd0, m_tag}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        do_reset();
        @(negedge clk);
        chk("idle_s_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;

        // One full frame streamed continuously, then digit 7
        send_frame(0, 1'b0);
        chk("t1_run_len", last_run, FP);
        pulse_digit(4'd7);
        @(negedge clk);
        chk("t1_m_valid", {31'd0, m_valid}, 32'd1);
        chk("t1_m_digit", {28'd0, m_digit}, 32'd7);
        chk("t1_m_tag", {24'd0, m_tag}, 32'd0);
        drain_results();
        chk("t1_frame_err", {31'd0, frame_err}, 32'd0);

        // Spurious core result with nothing outstanding
        pulse_digit(4'd3);
        @(negedge clk);
        chk("t4_frame_err", {31'd0, frame_err}, 32'd1);
        chk("t4_m_valid", {31'd0, m_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_m_valid_late", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("t4_err_cleared", {31'd0, frame_err}, 32'd0);
        @(posedge clk);
        #1;

        // Results blocked: four frames admitted, the fifth stalls until one pop
        m_ready = 1'b0;
        for (int f = 0; f < DEPTH; f++) begin
            send_frame(1, 1'b0);
            pulse_digit(4'(f + 1));
        end
        s_pixels = $urandom;
        s_last   = 1'b0;
        s_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t2_blocked", {31'd0, s_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("t2_ready_pop_cycle", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("t2_ready_after_pop", {31'd0, s_ready}, 32'd1);
        chk("t2_remaining", res_q.size(), 32'd3);
        @(posedge clk);
        #1;
        send_frame(1, 1'b0);
        pulse_digit(4'd9);
        m_ready = 1'b1;
        drain_results();
        chk("t2_frame_err", {31'd0, frame_err}, 32'd0);
        do_reset();

        // Bad s_last on beats 100 and 195; frame still completes by internal count
        send_frame(0, 1'b1);
        chk("t3_frame_err", {31'd0, frame_err}, 32'd1);
        pulse_digit(4'd5);
        drain_results();
        send_frame(1, 1'b0);
        pulse_digit(4'd2);
        drain_results();
        chk("t3_err_sticky", {31'd0, frame_err}, 32'd1);

        // Reset after beat 50
        send_beats(51, 1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_s_ready_rst", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        chk("t5_core_i_valid", {31'd0, core_i_valid}, 32'd0);
        chk("t5_core_pixel", {24'd0, core_pixel}, 32'd0);
        chk("t5_s_ready_rst2", {31'd0, s_ready}, 32'd0);
        chk("t5_frame_err", {31'd0, frame_err}, 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        send_frame(0, 1'b0);
        pulse_digit(4'd4);
        @(negedge clk);
        chk("t5_m_tag", {24'd0, m_tag}, 32'd0);
        chk("t5_m_digit", {28'd0, m_digit}, 32'd4);
        drain_results();

        // Head result held stable while a second result queues behind it
        m_ready = 1'b0;
        send_frame(1, 1'b0);
        pulse_digit(4'd3);
        send_frame(1, 1'b0);
        pulse_digit(4'd8);
        head = res_q[0];
        repeat (10) begin
            @(negedge clk);
            chk("t6_hold_valid", {31'd0, m_valid}, 32'd1);
            chk("t6_hold_tag", {24'd0, m_tag}, {24'd0, head[TW+3:4]});
            chk("t6_hold_digit", {28'd0, m_digit}, {28'd0, head[3:0]});
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain_results();
        @(negedge clk);
        chk("t6_empty", {31'd0, m_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout reached at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "bench timeout");
    end
endmodule
